// File: rtl/except_ctrl_pkg.sv
// Shared exception/CP0 definitions: cause codes, handler vector, CP0 register
// addresses and the exception-control FSM encodings.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

  localparam logic [31:0] EXC_HANDLER_ADDR = 32'h0000_0020;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  typedef struct packed {
    logic eret;
    logic overflow;
    logic trap;
    logic invalid_inst;
    logic syscall;
  } exc_flags_t;

  // Interrupts outrank every synchronous exception; eret is the weakest.
  function automatic logic [31:0] exc_code(input logic int_pend, input exc_flags_t f);
    logic [31:0] code;
    code = EXC_NONE;
    if (int_pend)            code = EXC_INT;
    else if (f.invalid_inst) code = EXC_INVALID;
    else if (f.syscall)      code = EXC_SYSCALL;
    else if (f.trap)         code = EXC_TRAP;
    else if (f.overflow)     code = EXC_OVERFLOW;
    else if (f.eret)         code = EXC_ERET;
    return code;
  endfunction

endpackage

// File: rtl/except_ctrl_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = rst ? '0 : d_i;
    sync_d = rst ? '0 : meta_q;
  end

  always_ff @(posedge clk) begin
    meta_q <= meta_d;
    sync_q <= sync_d;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: forwards in-flight CP0 writes, prioritizes
// interrupts/exceptions, commits to CP0 and drives the pipeline flush.
module except_ctrl
  import except_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_is_in_delayslot_i,
  input  logic [4:0]  mem_exc_flags_i,
  input  logic        mem_cp0_we_i,
  input  logic [4:0]  mem_cp0_waddr_i,
  input  logic [31:0] mem_cp0_wdata_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        stall_i,
  output logic [5:0]  cp0_int_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  logic [5:0]  int_sync;
  logic [1:0]  state_d, state_q;
  logic [31:0] status_fwd, cause_fwd, epc_fwd;
  logic        int_pend, exc_valid;
  exc_flags_t  flags;

  sync_2ff #(.WIDTH(6)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d_i (int_i),
    .q_o (int_sync)
  );

  assign flags = exc_flags_t'(mem_exc_flags_i);

  // Use the MEM instruction's own CP0 write so e.g. clearing IE takes effect at once.
  always_comb begin
    status_fwd = cp0_status_i;
    cause_fwd  = cp0_cause_i;
    epc_fwd    = cp0_epc_i;
    if (mem_cp0_we_i) begin
      if (mem_cp0_waddr_i == CP0_REG_STATUS) status_fwd = mem_cp0_wdata_i;
      if (mem_cp0_waddr_i == CP0_REG_CAUSE)  cause_fwd[9:8] = mem_cp0_wdata_i[9:8];
      if (mem_cp0_waddr_i == CP0_REG_EPC)    epc_fwd = mem_cp0_wdata_i;
    end
  end

  assign int_pend  = (|(cause_fwd[15:8] & status_fwd[15:8])) && status_fwd[0] && !status_fwd[1];
  assign exc_valid = !rst && (state_q == ST_IDLE) && (mem_pc_i != 32'h0) && !stall_i;

  always_comb begin
    excepttype_o        = exc_valid ? exc_code(int_pend, flags) : EXC_NONE;
    flush_o             = (excepttype_o != EXC_NONE);
    new_pc_o            = 32'h0;
    if (flush_o) new_pc_o = (excepttype_o == EXC_ERET) ? epc_fwd : EXC_HANDLER_ADDR;
    current_inst_addr_o = rst ? 32'h0 : mem_pc_i;
    is_in_delayslot_o   = rst ? 1'b0  : mem_is_in_delayslot_i;
    cp0_int_o           = rst ? 6'h0  : (int_sync | {timer_int_i, 5'b0});
  end

  // Two dead cycles after a flush let the redirected fetch settle before arbitration resumes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (flush_o) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (rst) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  logic unused_fwd;
  assign unused_fwd = ^{status_fwd[31:16], status_fwd[7:2], cause_fwd[31:16], cause_fwd[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl.
module tb_except_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] mem_pc_i;
  logic        mem_is_in_delayslot_i;
  logic [4:0]  mem_exc_flags_i;
  logic        mem_cp0_we_i;
  logic [4:0]  mem_cp0_waddr_i;
  logic [31:0] mem_cp0_wdata_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        stall_i;
  logic [5:0]  cp0_int_o;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;

  int n_cmp = 0;
  int n_bad = 0;

  except_ctrl dut (
    .clk(clk), .rst(rst), .int_i(int_i), .timer_int_i(timer_int_i),
    .mem_pc_i(mem_pc_i), .mem_is_in_delayslot_i(mem_is_in_delayslot_i),
    .mem_exc_flags_i(mem_exc_flags_i), .mem_cp0_we_i(mem_cp0_we_i),
    .mem_cp0_waddr_i(mem_cp0_waddr_i), .mem_cp0_wdata_i(mem_cp0_wdata_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .stall_i(stall_i), .cp0_int_o(cp0_int_o), .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_exc(input string tag, input logic [31:0] et, input logic fl, input logic [31:0] npc);
    #1;
    chk({tag, ".type"}, excepttype_o, et);
    chk({tag, ".flush"}, {31'b0, flush_o}, {31'b0, fl});
    chk({tag, ".newpc"}, new_pc_o, npc);
  endtask

  task automatic chk_quiet_outputs(input string tag);
    #1;
    chk({tag, ".type"}, excepttype_o, 32'h0);
    chk({tag, ".flush"}, {31'b0, flush_o}, 32'h0);
    chk({tag, ".newpc"}, new_pc_o, 32'h0);
    chk({tag, ".int"}, {26'b0, cp0_int_o}, 32'h0);
    chk({tag, ".addr"}, current_inst_addr_o, 32'h0);
    chk({tag, ".ds"}, {31'b0, is_in_delayslot_o}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; int_i = 6'h3f; timer_int_i = 1'b1;
    mem_pc_i = 32'h1000; mem_is_in_delayslot_i = 1'b1; mem_exc_flags_i = 5'b00001;
    mem_cp0_we_i = 1'b0; mem_cp0_waddr_i = 5'd0; mem_cp0_wdata_i = 32'h0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0; stall_i = 1'b0;

    // Reset holds everything at zero even with live inputs
    tick(); tick();
    chk_quiet_outputs("rst");

    int_i = 6'h0; timer_int_i = 1'b0; mem_pc_i = 32'h0; mem_exc_flags_i = 5'b0;
    mem_is_in_delayslot_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Syscall: immediate flush, then two masked cycles
    mem_pc_i = 32'h1000; mem_exc_flags_i = 5'b00001;
    chk_exc("sys", 32'h8, 1'b1, 32'h20);
    chk("sys.addr", current_inst_addr_o, 32'h1000);
    chk("sys.ds", {31'b0, is_in_delayslot_o}, 32'h0);
    tick(); chk_exc("sys.flush1", 32'h0, 1'b0, 32'h0);
    tick(); chk_exc("sys.flush2", 32'h0, 1'b0, 32'h0);
    tick(); chk_exc("sys.again", 32'h8, 1'b1, 32'h20);
    mem_exc_flags_i = 5'b0;

    // Bubble never raises
    mem_pc_i = 32'h0; mem_exc_flags_i = 5'b00001;
    chk_exc("bubble", 32'h0, 1'b0, 32'h0);
    mem_exc_flags_i = 5'b0;

    // Priority ladder with interrupts disabled
    mem_pc_i = 32'h1100;
    mem_exc_flags_i = 5'b11110; chk_exc("pri.inv", 32'ha, 1'b1, 32'h20);
    mem_exc_flags_i = 5'b11101; chk_exc("pri.sys", 32'h8, 1'b1, 32'h20);
    mem_exc_flags_i = 5'b11100; chk_exc("pri.trap", 32'hd, 1'b1, 32'h20);
    mem_exc_flags_i = 5'b11000; chk_exc("pri.ovf", 32'hc, 1'b1, 32'h20);
    mem_exc_flags_i = 5'b10000; cp0_epc_i = 32'h3000;
    chk_exc("eret.epc", 32'he, 1'b1, 32'h3000);
    mem_cp0_we_i = 1'b1; mem_cp0_waddr_i = 5'd14; mem_cp0_wdata_i = 32'h4000;
    chk_exc("eret.fwd", 32'he, 1'b1, 32'h4000);
    mem_cp0_waddr_i = 5'd13;
    chk_exc("eret.nofwd", 32'he, 1'b1, 32'h3000);
    mem_cp0_we_i = 1'b0; mem_exc_flags_i = 5'b0; mem_pc_i = 32'h0;

    // Interrupt synchronizer latency and timer OR
    cp0_status_i = 32'h0000_FF01;
    tick();
    int_i[2] = 1'b1;
    tick(); #1; chk("sync.1clk", {26'b0, cp0_int_o}, 32'h0);
    tick(); #1; chk("sync.2clk", {26'b0, cp0_int_o}, 32'h04);
    timer_int_i = 1'b1; #1;
    chk("timer", {26'b0, cp0_int_o}, 32'h24);
    timer_int_i = 1'b0;

    // Interrupt taken, masked through FLUSH/SETTLE, retaken on IDLE
    cp0_cause_i = 32'h0000_0400; mem_pc_i = 32'h2004; mem_is_in_delayslot_i = 1'b1;
    chk_exc("int", 32'h1, 1'b1, 32'h20);
    chk("int.addr", current_inst_addr_o, 32'h2004);
    chk("int.ds", {31'b0, is_in_delayslot_o}, 32'h1);
    tick(); chk_exc("int.mask1", 32'h0, 1'b0, 32'h0);
    tick(); chk_exc("int.mask2", 32'h0, 1'b0, 32'h0);
    tick(); chk_exc("int.retake", 32'h1, 1'b1, 32'h20);
    mem_is_in_delayslot_i = 1'b0;

    // Interrupt vs invalid, then in-flight IE clear
    mem_exc_flags_i = 5'b00010;
    chk_exc("intinv", 32'h1, 1'b1, 32'h20);
    mem_cp0_we_i = 1'b1; mem_cp0_waddr_i = 5'd12; mem_cp0_wdata_i = 32'h0000_FF00;
    chk_exc("intinv.ie0", 32'ha, 1'b1, 32'h20);
    mem_exc_flags_i = 5'b0;
    chk_exc("ie0.only", 32'h0, 1'b0, 32'h0);
    mem_cp0_we_i = 1'b0;

    // EXL set blocks interrupts
    cp0_status_i = 32'h0000_FF03;
    chk_exc("exl", 32'h0, 1'b0, 32'h0);

    // In-flight cause write only reaches software bits [9:8]
    cp0_status_i = 32'h0000_0101; cp0_cause_i = 32'h0;
    mem_cp0_we_i = 1'b1; mem_cp0_waddr_i = 5'd13; mem_cp0_wdata_i = 32'h0000_0100;
    chk_exc("cause.sw", 32'h1, 1'b1, 32'h20);
    cp0_status_i = 32'h0000_FC01; mem_cp0_wdata_i = 32'h0000_FC00;
    chk_exc("cause.hw", 32'h0, 1'b0, 32'h0);
    mem_cp0_we_i = 1'b0; cp0_status_i = 32'h0; int_i = 6'h0;

    // Stall defers overflow
    mem_pc_i = 32'h6000; mem_exc_flags_i = 5'b01000; stall_i = 1'b1;
    chk_exc("stall.0", 32'h0, 1'b0, 32'h0);
    tick(); chk_exc("stall.1", 32'h0, 1'b0, 32'h0);
    tick(); chk_exc("stall.2", 32'h0, 1'b0, 32'h0);
    tick(); stall_i = 1'b0;
    chk_exc("stall.rel", 32'hc, 1'b1, 32'h20);

    // Reset during FLUSH
    tick();
    chk_exc("inflush", 32'h0, 1'b0, 32'h0);
    rst = 1'b1; mem_pc_i = 32'h0; mem_exc_flags_i = 5'b0;
    chk_quiet_outputs("rstflush");
    tick();
    rst = 1'b0;
    chk_exc("postrst", 32'h0, 1'b0, 32'h0);
    mem_pc_i = 32'h6000; mem_exc_flags_i = 5'b01000;
    chk_exc("postrst.idle", 32'hc, 1'b1, 32'h20);
    mem_exc_flags_i = 5'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
